// File: rtl/store_buffer.sv
// store_buffer: store queue in front of the wishbone store unit.
// Accepts byte/halfword/word stores, checks alignment, and queues each
// legal store as a word-addressed entry with lane-shifted data and byte
// enables. Entries drain one at a time through a write/valid handshake.
// A combinational hazard check flags loads that hit a pending store.
//
// Ports:
//   clk, rst_i                 clock, async active-high reset
//   req_valid_i / req_ready_o  request handshake from the memory stage
//   req_addr_i/data_i/size_i   byte address, right-aligned data, size
//   err_o                      one-cycle pulse after a dropped bad request
//   empty_o                    no entries pending (including in flight)
//   chk_addr_i / chk_hit_o     load-address hazard check
//   write_o/addr_o/data_o/we_o store-unit request, held while BUSY
//   valid_i                    store-unit completion for current write
//
// Drain FSM:
//   state | meaning
//   IDLE  | nothing in flight, queue empty
//   BUSY  | head entry presented on write_o, waiting for valid_i
//   GAP   | one idle bus cycle after completion
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_data_i,
  input  logic [1:0]  req_size_i,
  output logic        err_o,
  output logic        empty_o,
  input  logic [31:0] chk_addr_i,
  output logic        chk_hit_o,
  output logic        write_o,
  output logic [31:0] addr_o,
  output logic [31:0] data_o,
  output logic [3:0]  we_o,
  input  logic        valid_i
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

  state_t         state, state_nx;
  logic [AW-1:0]  rd_ptr, wr_ptr;
  logic [AW:0]    count;
  logic [29:0]    mem_addr [DEPTH];
  logic [31:0]    mem_data [DEPTH];
  logic [3:0]     mem_we   [DEPTH];

  logic           req_ok;
  logic [3:0]     req_we;
  logic [31:0]    req_lane_data;
  logic           accept, push, pop;
  logic           unused_chk;

  // Word granularity hazard check; byte offset bits do not matter.
  assign unused_chk = ^chk_addr_i[1:0];

  always_comb begin
    req_ok        = 1'b0;
    req_we        = 4'b0000;
    req_lane_data = 32'h0;
    case (req_size_i)
      2'b00: begin
        req_ok        = 1'b1;
        req_we        = 4'b0001 << req_addr_i[1:0];
        req_lane_data = {4{req_data_i[7:0]}};
      end
      2'b01: begin
        req_ok        = ~req_addr_i[0];
        req_we        = req_addr_i[1] ? 4'b1100 : 4'b0011;
        req_lane_data = {2{req_data_i[15:0]}};
      end
      2'b10: begin
        req_ok        = (req_addr_i[1:0] == 2'b00);
        req_we        = 4'b1111;
        req_lane_data = req_data_i;
      end
      default: ;
    endcase
  end

  // No pass-through when full: ready depends only on the stored count.
  assign req_ready_o = (count != (AW+1)'(DEPTH));
  assign accept      = req_valid_i && req_ready_o;
  assign push        = accept && req_ok;
  assign pop         = (state == BUSY) && valid_i;

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state  <= IDLE;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      err_o  <= 1'b0;
    end else begin
      state <= state_nx;
      err_o <= accept && !req_ok;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Entry storage needs no reset: it is only observed through count/BUSY.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr] <= req_addr_i[31:2];
      mem_data[wr_ptr] <= req_lane_data;
      mem_we[wr_ptr]   <= req_we;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (count != '0 || push) state_nx = BUSY;
      BUSY:    if (valid_i) state_nx = GAP;
      GAP:     state_nx = (count != '0 || push) ? BUSY : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign write_o = (state == BUSY);
  assign addr_o  = write_o ? {mem_addr[rd_ptr], 2'b00} : 32'h0;
  assign data_o  = write_o ? mem_data[rd_ptr] : 32'h0;
  assign we_o    = write_o ? mem_we[rd_ptr] : 4'b0000;
  assign empty_o = (count == '0);

  // Scan occupied slots from the head, including the in-flight entry.
  always_comb begin
    chk_hit_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (((AW+1)'(i) < count) &&
          (mem_addr[rd_ptr + AW'(i)] == chk_addr_i[31:2]))
        chk_hit_o = 1'b1;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_addr_i;
  logic [31:0] req_data_i;
  logic [1:0]  req_size_i;
  logic        err_o;
  logic        empty_o;
  logic [31:0] chk_addr_i;
  logic        chk_hit_o;
  logic        write_o;
  logic [31:0] addr_o;
  logic [31:0] data_o;
  logic [3:0]  we_o;
  logic        valid_i;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_data_i(req_data_i), .req_size_i(req_size_i),
    .err_o(err_o), .empty_o(empty_o),
    .chk_addr_i(chk_addr_i), .chk_hit_o(chk_hit_o),
    .write_o(write_o), .addr_o(addr_o), .data_o(data_o), .we_o(we_o),
    .valid_i(valid_i)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  we;
  } entry_t;

  // Reference model: pending stores in order, plus the two cycle-level rules
  // "write is shown when something is pending, except the cycle after an ack"
  // and "err pulses the cycle after a dropped request".
  entry_t mq[$];
  logic   exp_write;
  logic   exp_err;
  int     checks = 0;
  int     failures = 0;

  task automatic model_reset();
    mq.delete();
    exp_write = 1'b0;
    exp_err   = 1'b0;
  endtask

  function automatic void expect_entry(input logic [31:0] a, input logic [31:0] d,
                                       input logic [1:0] s, output bit ok, output entry_t e);
    e.addr = a & 32'hFFFF_FFFC;
    e.data = 32'h0;
    e.we   = 4'h0;
    ok     = 1'b0;
    case (s)
      2'd0: begin ok = 1'b1; e.we = 4'(1 << (a % 4)); e.data = {24'h0, d[7:0]} * 32'h0101_0101; end
      2'd1: begin ok = ((a % 2) == 0); e.we = ((a % 4) >= 2) ? 4'hC : 4'h3;
                  e.data = {16'h0, d[15:0]} * 32'h0001_0001; end
      2'd2: begin ok = ((a % 4) == 0); e.we = 4'hF; e.data = d; end
      default: ok = 1'b0;
    endcase
  endfunction

  // Drive one clock cycle of inputs (from a negedge) and advance the model.
  task automatic cycle(input bit v, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] s, input bit ack);
    bit acc, ok, ack_eff;
    entry_t e, popped;
    req_valid_i = v; req_addr_i = a; req_data_i = d; req_size_i = s; valid_i = ack;
    acc = v && (mq.size() < DEPTH);
    expect_entry(a, d, s, ok, e);
    ack_eff = ack && exp_write;
    @(posedge clk);
    if (ack_eff) popped = mq.pop_front();
    if (acc && ok) mq.push_back(e);
    exp_err   = acc && !ok;
    exp_write = (mq.size() != 0) && !ack_eff;
    @(negedge clk);
    req_valid_i = 1'b0;
    valid_i     = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({write_o, req_ready_o, empty_o, chk_hit_o, err_o} !== 5'b01100) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=01100", {write_o, req_ready_o, empty_o, chk_hit_o, err_o});
    end
    checks++;
    if ({addr_o, data_o, we_o} !== 68'h0) begin
      failures++;
      $display("FAIL reset_bus got=%h/%h/%h exp=0", addr_o, data_o, we_o);
    end
  endtask

  task automatic test_single_word();
    cycle(1, 32'h1000_0004, 32'hDEAD_BEEF, 2'd2, 0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({write_o, addr_o, we_o, data_o} !== {1'b1, 32'h1000_0004, 4'hF, 32'hDEAD_BEEF}) begin
        failures++;
        $display("FAIL word_hold%0d got=%b %h %h %h", i, write_o, addr_o, we_o, data_o);
      end
      if (i < 3) cycle(0, 0, 0, 0, 0);
    end
    cycle(0, 0, 0, 0, 1);
    checks++;
    if ({write_o, empty_o} !== 2'b01) begin
      failures++;
      $display("FAIL word_gap got=%b exp=01", {write_o, empty_o});
    end
    cycle(0, 0, 0, 0, 0);
    checks++;
    if ({write_o, empty_o, addr_o} !== {2'b01, 32'h0}) begin
      failures++;
      $display("FAIL word_idle got=%b %h", {write_o, empty_o}, addr_o);
    end
  endtask

  task automatic test_sub_word();
    cycle(1, 32'h1000_0003, 32'h0000_00AB, 2'd0, 0);
    checks++;
    if ({write_o, addr_o, we_o, data_o} !== {1'b1, 32'h1000_0000, 4'b1000, 32'hABAB_ABAB}) begin
      failures++;
      $display("FAIL byte_lane got=%b %h %b %h", write_o, addr_o, we_o, data_o);
    end
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0);
    cycle(1, 32'h1000_0002, 32'h0000_1234, 2'd1, 0);
    checks++;
    if ({write_o, addr_o, we_o, data_o} !== {1'b1, 32'h1000_0000, 4'b1100, 32'h1234_1234}) begin
      failures++;
      $display("FAIL half_lane got=%b %h %b %h", write_o, addr_o, we_o, data_o);
    end
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0);
  endtask

  task automatic test_misalign();
    logic [31:0] addrs [3];
    logic [1:0]  sizes [3];
    addrs[0] = 32'h1000_0001; sizes[0] = 2'd1;
    addrs[1] = 32'h1000_0002; sizes[1] = 2'd2;
    addrs[2] = 32'h1000_0000; sizes[2] = 2'd3;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (req_ready_o !== 1'b1) begin
        failures++;
        $display("FAIL mis_ready%0d got=%b exp=1", i, req_ready_o);
      end
      cycle(1, addrs[i], $urandom, sizes[i], 0);
      checks++;
      if ({err_o, write_o, empty_o} !== 3'b101) begin
        failures++;
        $display("FAIL mis_err%0d got=%b exp=101", i, {err_o, write_o, empty_o});
      end
      cycle(0, 0, 0, 0, 0);
      checks++;
      if ({err_o, write_o} !== 2'b00) begin
        failures++;
        $display("FAIL mis_pulse%0d got=%b exp=00", i, {err_o, write_o});
      end
    end
  endtask

  task automatic test_full_wrap();
    for (int i = 0; i < 4; i++)
      cycle(1, 32'h4000_0000 + 32'(4 * i), 32'h1111_1111 * 32'(i + 1), 2'd2, 0);
    checks++;
    if ({req_ready_o, write_o, data_o} !== {2'b01, 32'h1111_1111}) begin
      failures++;
      $display("FAIL full_ready got=%b %h", {req_ready_o, write_o}, data_o);
    end
    cycle(1, 32'h4000_0010, 32'h5555_5555, 2'd2, 0);
    checks++;
    if (req_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL full_wait got=%b exp=0", req_ready_o);
    end
    cycle(1, 32'h4000_0010, 32'h5555_5555, 2'd2, 1);
    checks++;
    if ({req_ready_o, write_o} !== 2'b10) begin
      failures++;
      $display("FAIL full_popgap got=%b exp=10", {req_ready_o, write_o});
    end
    cycle(1, 32'h4000_0010, 32'h5555_5555, 2'd2, 0);
    for (int n = 0; n < 40 && mq.size() != 0; n++) begin
      checks++;
      if (write_o !== exp_write) begin
        failures++;
        $display("FAIL drain_write got=%b exp=%b", write_o, exp_write);
      end
      if (exp_write) begin
        checks++;
        if ({addr_o, data_o, we_o} !== {mq[0].addr, mq[0].data, mq[0].we}) begin
          failures++;
          $display("FAIL drain_order got=%h %h exp=%h %h", addr_o, data_o, mq[0].addr, mq[0].data);
        end
      end
      cycle(0, 0, 0, 0, 1);
    end
    cycle(0, 0, 0, 0, 0);
    checks++;
    if ({empty_o, write_o} !== 2'b10) begin
      failures++;
      $display("FAIL drain_done got=%b exp=10", {empty_o, write_o});
    end
  endtask

  task automatic test_hazard();
    cycle(1, 32'h2000_0008, $urandom, 2'd2, 0);
    chk_addr_i = 32'h2000_000A; #1;
    checks++;
    if (chk_hit_o !== 1'b1) begin failures++; $display("FAIL haz_hit got=%b exp=1", chk_hit_o); end
    chk_addr_i = 32'h2000_000C; #1;
    checks++;
    if (chk_hit_o !== 1'b0) begin failures++; $display("FAIL haz_miss got=%b exp=0", chk_hit_o); end
    cycle(0, 0, 0, 0, 1);
    chk_addr_i = 32'h2000_000A; #1;
    checks++;
    if (chk_hit_o !== 1'b0) begin failures++; $display("FAIL haz_popped got=%b exp=0", chk_hit_o); end
    @(negedge clk);
    chk_addr_i = 32'h0;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) cycle(1, 32'h5000_0000 + 32'(4 * i), $urandom, 2'd2, 0);
    #2 rst_i = 1'b1;
    #1;
    checks++;
    if ({write_o, empty_o, req_ready_o} !== 3'b011) begin
      failures++;
      $display("FAIL rst_async got=%b exp=011", {write_o, empty_o, req_ready_o});
    end
    model_reset();
    @(negedge clk);
    rst_i = 1'b0;
    cycle(1, 32'h5000_0010, 32'hCAFE_F00D, 2'd2, 0);
    checks++;
    if ({write_o, addr_o, data_o} !== {1'b1, 32'h5000_0010, 32'hCAFE_F00D}) begin
      failures++;
      $display("FAIL rst_after got=%b %h %h", write_o, addr_o, data_o);
    end
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0);
    checks++;
    if ({write_o, empty_o} !== 2'b01) begin
      failures++;
      $display("FAIL rst_drain got=%b exp=01", {write_o, empty_o});
    end
  endtask

  task automatic test_random();
    bit hit;
    for (int n = 0; n < 400; n++) begin
      if (mq.size() != 0 && $urandom_range(0, 1) == 1)
        chk_addr_i = mq[$urandom_range(0, mq.size() - 1)].addr | 32'($urandom_range(0, 3));
      else
        chk_addr_i = 32'h3000_0000 | 32'($urandom_range(0, 15));
      #1;
      hit = 1'b0;
      for (int k = 0; k < mq.size(); k++)
        if (mq[k].addr[31:2] == chk_addr_i[31:2]) hit = 1'b1;
      checks++;
      if ({write_o, err_o, empty_o, req_ready_o, chk_hit_o} !==
          {exp_write, exp_err, mq.size() == 0, mq.size() < DEPTH, hit}) begin
        failures++;
        $display("FAIL rnd_flags n=%0d got=%b exp=%b", n, {write_o, err_o, empty_o, req_ready_o, chk_hit_o},
                 {exp_write, exp_err, mq.size() == 0, mq.size() < DEPTH, hit});
      end
      checks++;
      if (exp_write) begin
        if ({addr_o, data_o, we_o} !== {mq[0].addr, mq[0].data, mq[0].we}) begin
          failures++;
          $display("FAIL rnd_head n=%0d got=%h %h %h exp=%h %h %h", n, addr_o, data_o, we_o,
                   mq[0].addr, mq[0].data, mq[0].we);
        end
      end else if ({addr_o, data_o, we_o} !== 68'h0) begin
        failures++;
        $display("FAIL rnd_idlebus n=%0d got=%h %h %h exp=0", n, addr_o, data_o, we_o);
      end
      cycle($urandom_range(0, 2) != 0, 32'h3000_0000 | 32'($urandom_range(0, 15)), $urandom,
            ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2)), $urandom_range(0, 1) == 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_i = 1'b1;
    req_valid_i = 1'b0; req_addr_i = 32'h0; req_data_i = 32'h0; req_size_i = 2'd0;
    chk_addr_i = 32'h0; valid_i = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    test_reset();
    test_single_word();
    test_sub_word();
    test_misalign();
    test_full_wrap();
    test_hazard();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
